// File: rtl/mul_r4_pkg.sv
// Shared types for the radix-4 Booth multiplier: controller states and the
// recoded digit produced from each 3-bit multiplier window.
package mul_r4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    // Digit value = (neg ? -1 : +1) * (two ? 2 : 1), or 0 when zero is set.
    typedef struct packed {
        logic zero;
        logic neg;
        logic two;
    } booth_digit_t;

endpackage

// File: rtl/booth_r4_enc.sv
// Combinational radix-4 Booth recoder: window {x[2i+1], x[2i], x[2i-1]}
// maps to a digit in {-2,-1,0,+1,+2}.
module booth_r4_enc
    import mul_r4_pkg::*;
(
    input  logic [2:0]   window_i,
    output booth_digit_t digit_o
);

    always_comb begin
        digit_o      = '0;
        digit_o.zero = (window_i == 3'b000) || (window_i == 3'b111);
        digit_o.neg  = window_i[2] & ~(window_i[1] & window_i[0]);
        digit_o.two  = (window_i == 3'b011) || (window_i == 3'b100);
    end

endmodule

// File: rtl/mul_r4_param.sv
// Sequential radix-4 Booth multiplier with byte-serial operand loading.
// One Booth digit is accumulated per clock; WIDTH/2+1 digits cover both modes.
module mul_r4_param
    import mul_r4_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IN_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 getA,
    input  logic                 getX,
    input  logic                 signed_mode,
    input  logic [IN_W-1:0]      in,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int XW    = WIDTH + 3;
    localparam int ITER  = WIDTH / 2 + 1;
    localparam int CW    = $clog2(WIDTH / 2 + 2);

    mul_state_t        state_q;
    logic [WIDTH-1:0]  a_q, x_q;
    logic [PW-1:0]     mcand_q, acc_q, result_q;
    logic [XW-1:0]     mplier_q;
    logic [CW-1:0]     cnt_q;
    logic              mode_q, ready_q, busy_q;

    logic [WIDTH+IN_W-1:0] a_cat, x_cat;
    logic [WIDTH-1:0]  a_shift_d, x_shift_d;
    logic [PW-1:0]     ext_a_d, term_d, sum_d;
    logic [XW-1:0]     ext_x_d;
    logic              last_d;
    booth_digit_t      dig;

    booth_r4_enc u_enc (
        .window_i (mplier_q[2:0]),
        .digit_o  (dig)
    );

    // New bytes enter at the top, so the first byte loaded ends up as the LSB.
    assign a_cat     = {in, a_q};
    assign x_cat     = {in, x_q};
    assign a_shift_d = a_cat[WIDTH+IN_W-1:IN_W];
    assign x_shift_d = x_cat[WIDTH+IN_W-1:IN_W];

    assign ext_a_d = {{WIDTH{signed_mode & a_q[WIDTH-1]}}, a_q};
    assign ext_x_d = {{2{signed_mode & x_q[WIDTH-1]}}, x_q, 1'b0};

    // Negative digits use one's complement plus carry-in on the single adder.
    assign term_d = dig.zero ? '0 : (dig.two ? {mcand_q[PW-2:0], 1'b0} : mcand_q);
    assign sum_d  = acc_q + (term_d ^ {PW{dig.neg}}) + {{(PW-1){1'b0}}, dig.neg};
    assign last_d = (cnt_q == CW'(ITER - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            x_q      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (getA) a_q <= a_shift_d;
                    if (getX) x_q <= x_shift_d;
                    if (start) begin
                        mode_q   <= signed_mode;
                        mcand_q  <= ext_a_d;
                        mplier_q <= ext_x_d;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                        state_q  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q    <= sum_d;
                    mcand_q  <= {mcand_q[PW-3:0], 2'b00};
                    mplier_q <= {{2{mode_q & mplier_q[XW-1]}}, mplier_q[XW-1:2]};
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_d) begin
                        result_q <= sum_d;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign ready  = ready_q;
    assign busy   = busy_q;

endmodule

// File: doc/mul_r4_param.md
MUL_R4_PARAM -- requirements
Module: mul_r4_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits, a multiple of 8 and at least 8.
REQ-002 SHALL have parameter IN_W, fixed at 8, load-bus width.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, level sampled each edge; starts a multiply from IDLE or DONE.
REQ-006 SHALL have port getA, input, 1; each edge with getA=1 loads one byte of multiplicand A.
REQ-007 SHALL have port getX, input, 1; each edge with getX=1 loads one byte of multiplier X.
REQ-008 SHALL have port signed_mode, input, 1: 1 = two's complement, 0 = unsigned; sampled with start.
REQ-009 SHALL have port in, input, IN_W, byte load bus.
REQ-010 SHALL have port result, output, 2*WIDTH, product register.
REQ-011 SHALL have port ready, output, 1: result valid.
REQ-012 SHALL have port busy, output, 1: multiply in progress.

Function
REQ-013 SHALL shift A as A <= {in, A[WIDTH-1:8]} on each getA edge; the same rule applies to X with getX. After WIDTH/8 strobes, the first byte is the LSB. Extra strobes keep shifting.
REQ-014 SHALL ignore getA and getX while busy=1. If getA and getX are both high on the same edge, both registers SHALL load the same byte.
REQ-015 SHALL use FSM states IDLE, CALC and DONE, with these transitions:
- IDLE -> CALC when start=1.
- CALC -> DONE after the last iteration.
- DONE -> CALC when start=1.
- No other transitions.
REQ-016 SHALL, on the start edge:
- latch signed_mode;
- extend X by 2 bits (sign-extend if signed, zero-extend if unsigned) and append an implicit 0 below the LSB;
- extend A to 2*WIDTH by the same rule;
- clear the accumulator, set busy=1 and clear ready.
REQ-017 SHALL perform WIDTH/2+1 radix-4 Booth iterations in CALC, one per clock.
- Each iteration recodes a 3-bit window of X to a digit in {-2,-1,0,+1,+2}.
- The digit times A, shifted left 2*i, is added to the accumulator modulo 2^(2*WIDTH).
REQ-018 SHALL assert ready=1 and busy=0 and write result on the edge of the final iteration. For start sampled at edge 0, ready SHALL rise after edge WIDTH/2+1 (9 for WIDTH=16).
REQ-019 SHALL hold result and ready stable in DONE until the next accepted start.
REQ-020 SHALL ignore start while in CALC.
REQ-021 SHALL leave the A/X registers unchanged by a multiply, so a repeated start recomputes the same operands.
REQ-022 SHALL produce a result equal to the exact product in 2*WIDTH bits for every operand pair in both modes, including the most negative value times the most negative value.

Reset
REQ-023 SHALL, on rst=1 and regardless of clk, clear result, A, X, accumulator, counter and latched mode to 0, set ready=0 and busy=0, and enter IDLE.
REQ-024 SHALL abort a multiply in progress when reset is asserted; no partial result SHALL be visible afterwards.

Structure
REQ-025 SHALL take the FSM state enum and the Booth digit encoding type from package mul_r4_pkg.
REQ-026 SHALL contain one sub-module booth_r4_enc: combinational recoder from a 3-bit window to {zero, neg, two}.
REQ-027 SHALL contain one adder datapath of 2*WIDTH bits and a counter of width clog2(WIDTH/2+2).

Verification
REQ-028 SHALL verify, at WIDTH=16, signed: A bytes 0xFB,0xFF; X bytes 0x08,0x00; start -> result=0xFFFFFFD8, ready high after 9 edges.
REQ-029 SHALL verify the same operands unsigned -> result=0x0007FFD8.
REQ-030 SHALL verify signed A=X=0x8000 -> 0x40000000; unsigned A=X=0xFFFF -> 0xFFFE0001.
REQ-031 SHALL verify start and getA pulsed during CALC -> same result, and A unchanged afterwards.
REQ-032 SHALL verify rst raised at iteration 4 -> result=0, ready=0, busy=0 immediately; a new start then gives the correct product.
REQ-033 SHALL verify WIDTH=32 with random signed and unsigned operands against a reference model -> exact match, latency 17 edges.
